// File: rtl/match_controller_if.sv
// rtl/match_controller_if.sv - Signal bundle between the match sequencer and its neighbours
//
// timing_tick  1   one-cycle frame tick
// start        1   debounced start button level
// x_ball       11  ball X position
// state        2   0=START 1=PLAY 2=SERVE 3=GAME_OVER
// score_left   4   left player score
// score_right  4   right player score
// point_left   1   one-cycle pulse, left player scored
// point_right  1   one-cycle pulse, right player scored
// winner       1   0=left 1=right, valid in GAME_OVER
//
// slave: the match controller; master: the surrounding logic that drives it.
interface match_controller_if;
    logic        timing_tick;
    logic        start;
    logic [10:0] x_ball;
    logic [1:0]  state;
    logic [3:0]  score_left;
    logic [3:0]  score_right;
    logic        point_left;
    logic        point_right;
    logic        winner;

    modport master (
        output timing_tick, start, x_ball,
        input  state, score_left, score_right, point_left, point_right, winner
    );

    modport slave (
        input  timing_tick, start, x_ball,
        output state, score_left, score_right, point_left, point_right, winner
    );
endinterface

// File: rtl/match_controller.sv
// rtl/match_controller.sv - Pong game sequencer: serve countdown, goal detection, scoring, winner
//
// clk   in   system clock
// rst   in   synchronous, active-high reset
// bus   slave modport of match_controller_if
//       in : timing_tick, start, x_ball
//       out: state, score_left, score_right, point_left, point_right, winner
//
// All outputs are registered; an input event on cycle N is visible on cycle N+1.
module match_controller #(
    parameter int WIN_SCORE    = 7,
    parameter int SERVE_TICKS  = 120,
    parameter int LEFT_GOAL_X  = 8,
    parameter int RIGHT_GOAL_X = 1001
) (
    input  logic               clk,
    input  logic               rst,
    match_controller_if.slave  bus
);

    localparam int CW = $clog2(SERVE_TICKS + 1);

    localparam logic [CW-1:0] SERVE_LOAD = CW'(SERVE_TICKS);
    localparam logic [3:0]    WIN_VAL    = 4'(WIN_SCORE);
    localparam logic [10:0]   LEFT_X     = 11'(LEFT_GOAL_X);
    localparam logic [10:0]   RIGHT_X    = 11'(RIGHT_GOAL_X);

    typedef enum logic [1:0] {
        ST_START = 2'd0,
        ST_PLAY  = 2'd1,
        ST_SERVE = 2'd2,
        ST_OVER  = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    sl_q, sl_d;
    logic [3:0]    sr_q, sr_d;
    logic          pl_q, pl_d;
    logic          pr_q, pr_d;
    logic          win_q, win_d;
    logic          start_q;

    logic          start_edge;
    logic          hit_left_wall;
    logic          hit_right_wall;
    logic [3:0]    sl_inc;
    logic [3:0]    sr_inc;

    assign start_edge     = bus.start & ~start_q;
    // Ball at the left wall scores for the right player and vice versa.
    assign hit_left_wall  = (bus.x_ball <= LEFT_X);
    assign hit_right_wall = (bus.x_ball >= RIGHT_X);
    assign sl_inc         = sl_q + 4'd1;
    assign sr_inc         = sr_q + 4'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_START;
            cnt_q   <= '0;
            sl_q    <= 4'd0;
            sr_q    <= 4'd0;
            pl_q    <= 1'b0;
            pr_q    <= 1'b0;
            win_q   <= 1'b0;
            start_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sl_q    <= sl_d;
            sr_q    <= sr_d;
            pl_q    <= pl_d;
            pr_q    <= pr_d;
            win_q   <= win_d;
            start_q <= bus.start;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sl_d    = sl_q;
        sr_d    = sr_q;
        pl_d    = 1'b0;
        pr_d    = 1'b0;
        win_d   = win_q;

        case (state_q)
            ST_START: begin
                if (start_edge) begin
                    state_d = ST_SERVE;
                    cnt_d   = SERVE_LOAD;
                end
            end

            ST_SERVE: begin
                // Counter holds the ticks still to wait; the tick that finds
                // it at 1 is the last one spent in SERVE.
                if (bus.timing_tick) begin
                    if (cnt_q == CW'(1)) begin
                        state_d = ST_PLAY;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
            end

            ST_PLAY: begin
                // Leaving PLAY on the scoring edge guarantees one point per exit.
                if (hit_left_wall) begin
                    sr_d = sr_inc;
                    pr_d = 1'b1;
                    if (sr_inc == WIN_VAL) begin
                        state_d = ST_OVER;
                        win_d   = 1'b1;
                    end else begin
                        state_d = ST_SERVE;
                        cnt_d   = SERVE_LOAD;
                    end
                end else if (hit_right_wall) begin
                    sl_d = sl_inc;
                    pl_d = 1'b1;
                    if (sl_inc == WIN_VAL) begin
                        state_d = ST_OVER;
                        win_d   = 1'b0;
                    end else begin
                        state_d = ST_SERVE;
                        cnt_d   = SERVE_LOAD;
                    end
                end
            end

            ST_OVER: begin
                if (start_edge) begin
                    sl_d    = 4'd0;
                    sr_d    = 4'd0;
                    win_d   = 1'b0;
                    state_d = ST_SERVE;
                    cnt_d   = SERVE_LOAD;
                end
            end

            default: state_d = ST_START;
        endcase
    end

    assign bus.state       = state_q;
    assign bus.score_left  = sl_q;
    assign bus.score_right = sr_q;
    assign bus.point_left  = pl_q;
    assign bus.point_right = pr_q;
    assign bus.winner      = win_q;

endmodule
